// File: rtl/timer_irq_dev_if.sv
// timer_irq_dev_if: CPU bridge register bus and interrupt line of the down-counting timer
interface timer_irq_dev_if;
    logic [1:0]  addr;
    logic        we;
    logic [31:0] din;
    logic [31:0] dout;
    logic        irq;
    modport master (output addr, we, din, input dout, irq);
    modport slave  (input addr, we, din, output dout, irq);
endinterface

// File: rtl/timer_irq_dev.sv
// timer_irq_dev: programmable down-counting timer raising a CP0 HWInt request; TIMER_AUTO_RELOAD_EN enables mode 1 auto-reload
module timer_irq_dev #(
    parameter int               CNT_W      = 32,
    parameter logic [CNT_W-1:0] PRESET_RST = '0
) (
    input logic            clk,
    input logic            reset,
    timer_irq_dev_if.slave io_bus
);
    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_LOAD = 2'd1;
    localparam logic [1:0] S_CNT  = 2'd2;
    localparam logic [1:0] S_INT  = 2'd3;

    logic             r_en;
    logic             r_im;
    logic             r_flag;
    logic [1:0]       r_state;
    logic [CNT_W-1:0] r_preset;
    logic [CNT_W-1:0] r_count;
    logic [1:0]       w_mode;
    logic             w_reload;
    logic             w_wr_ctrl;
    logic             w_wr_preset;
    logic             w_ack;

    assign w_wr_ctrl   = io_bus.we && io_bus.addr == 2'd0;
    assign w_wr_preset = io_bus.we && io_bus.addr == 2'd1;
    // a write only acknowledges an interrupt that is actually being presented
    assign w_ack       = (w_wr_ctrl || w_wr_preset) && r_flag && r_im;
    assign io_bus.irq  = r_flag && r_im;

`ifdef TIMER_AUTO_RELOAD_EN
    logic [1:0] r_mode;
    assign w_mode   = r_mode;
    assign w_reload = r_mode == 2'd1;
    // mode field is software-writable only when auto-reload is built in
    always_ff @(posedge clk) begin
        if (reset)
            r_mode <= 2'd0;
        else if (w_wr_ctrl)
            r_mode <= io_bus.din[2:1];
    end
`else
    assign w_mode   = 2'd0;
    assign w_reload = 1'b0;
`endif

    // register read mux, zero-extended; reserved address reads 0
    always_comb begin
        io_bus.dout = io_bus.addr == 2'd0 ? {28'd0, r_im, w_mode, r_en} :
                      io_bus.addr == 2'd1 ? 32'(r_preset) :
                      io_bus.addr == 2'd2 ? 32'(r_count) : 32'd0;
    end

    // timer sequencing; expiry set beats ack clear, software CTRL write beats the one-shot disable
    always_ff @(posedge clk) begin
        if (reset) begin
            r_en     <= 1'b0;
            r_im     <= 1'b0;
            r_flag   <= 1'b0;
            r_state  <= S_IDLE;
            r_preset <= PRESET_RST;
            r_count  <= '0;
        end else begin
            if (w_ack)
                r_flag <= 1'b0;
            if (!r_en)
                r_state <= S_IDLE;
            else if (r_state == S_IDLE)
                r_state <= S_LOAD;
            else if (r_state == S_LOAD) begin
                r_count <= r_preset;
                r_state <= S_CNT;
            end else if (r_state == S_CNT) begin
                if (r_count != '0)
                    r_count <= r_count - CNT_W'(1);
                else begin
                    r_state <= S_INT;
                    r_flag  <= 1'b1;
                end
            end else if (w_reload) begin
                r_flag  <= 1'b0;
                r_count <= r_preset;
                r_state <= S_CNT;
            end else begin
                r_en    <= 1'b0;
                r_state <= S_IDLE;
            end
            if (w_wr_ctrl) begin
                r_en <= io_bus.din[0];
                r_im <= io_bus.din[3];
            end
            if (w_wr_preset)
                r_preset <= io_bus.din[CNT_W-1:0];
        end
    end
endmodule

// File: tb/tb_timer_irq_dev.sv
// tb_timer_irq_dev: directed literal checks plus randomized traffic against a timeline model of the timer
module tb_timer_irq_dev;
    localparam int         CW   = 8;
    localparam logic [7:0] PRST = 8'h2A;
`ifdef TIMER_AUTO_RELOAD_EN
    localparam bit AUTO = 1'b1;
`else
    localparam bit AUTO = 1'b0;
`endif

    logic clk = 1'b0;
    logic reset = 1'b0;
    int   n_chk = 0;
    int   n_fail = 0;

    timer_irq_dev_if bus();

    timer_irq_dev #(.CNT_W(CW), .PRESET_RST(PRST)) dut (
        .clk    (clk),
        .reset  (reset),
        .io_bus (bus)
    );

    always #5 clk = ~clk;

    // Timeline model: a run is described by the edge its COUNT was loaded, the loaded
    // value and the edge at which it expires; COUNT is derived arithmetically.
    bit         m_valid = 1'b0;
    bit         m_en, m_im, m_flag, m_int;
    logic [1:0] m_mode;
    logic [7:0] m_preset, m_cnt;
    longint     m_n = 0, m_load = -1, m_exp = -1, m_t0 = 0, m_base = 0;

    always @(posedge clk) begin
        bit wc, wp;
        m_n++;
        wc = bus.we && bus.addr == 2'd0;
        wp = bus.we && bus.addr == 2'd1;
        if (reset) begin
            m_en = 0; m_im = 0; m_flag = 0; m_int = 0; m_mode = 0;
            m_preset = PRST; m_cnt = 0; m_load = -1; m_exp = -1; m_valid = 1;
        end else begin
            if ((wc || wp) && m_flag && m_im)
                m_flag = 0;
            if (!m_en) begin
                m_load = -1; m_exp = -1; m_int = 0;
            end else if (m_int) begin
                m_int = 0;
                if (AUTO && m_mode == 2'd1) begin
                    m_flag = 0; m_base = m_preset; m_t0 = m_n; m_exp = m_n + m_base + 1;
                end else
                    m_en = 0;
            end else if (m_load == m_n) begin
                m_base = m_preset; m_t0 = m_n; m_exp = m_n + m_base + 1; m_load = -1;
            end else if (m_exp == m_n) begin
                m_flag = 1; m_int = 1; m_exp = -1;
            end else if (m_load < 0 && m_exp < 0)
                m_load = m_n + 1;
            if (m_exp >= 0)
                m_cnt = 8'((m_base - (m_n - m_t0)) > 0 ? (m_base - (m_n - m_t0)) : 0);
            if (wc) begin
                m_en = bus.din[0];
                m_im = bus.din[3];
                m_mode = AUTO ? bus.din[2:1] : 2'd0;
            end
            if (wp)
                m_preset = bus.din[7:0];
        end
    end

    // cycle-by-cycle comparison of read data and irq against the model
    always @(negedge clk) begin
        logic [31:0] e_dout;
        if (m_valid) begin
            e_dout = bus.addr == 2'd0 ? {28'd0, m_im, m_mode, m_en} :
                     bus.addr == 2'd1 ? {24'd0, m_preset} :
                     bus.addr == 2'd2 ? {24'd0, m_cnt} : 32'd0;
            n_chk += 2;
            if (bus.dout !== e_dout) begin
                n_fail++;
                $display("FAIL model_dout t=%0t addr=%0d got %h expected %h", $time, bus.addr, bus.dout, e_dout);
            end
            if (bus.irq !== (m_flag && m_im)) begin
                n_fail++;
                $display("FAIL model_irq t=%0t got %b expected %b", $time, bus.irq, m_flag && m_im);
            end
        end
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic rd_chk(input string nm, input logic [1:0] a, input logic [31:0] exp);
        bus.addr = a;
        #1;
        chk(nm, bus.dout, exp);
    endtask

    task automatic wr(input logic [1:0] a, input logic [31:0] d);
        @(posedge clk); #1;
        bus.we = 1'b1; bus.addr = a; bus.din = d;
        @(posedge clk); #1;
        bus.we = 1'b0;
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial begin
        bus.we = 1'b0; bus.addr = 2'd0; bus.din = 32'd0;
        reset = 1'b1;
        step(2);
        reset = 1'b0;
        rd_chk("rst_ctrl", 2'd0, 32'd0);
        rd_chk("rst_count", 2'd2, 32'd0);
        rd_chk("rst_preset", 2'd1, 32'h2A);
        rd_chk("rst_reserved", 2'd3, 32'd0);
        chk("rst_irq", bus.irq, 1'b0);

        wr(2'd1, 32'd5);
        wr(2'd0, 32'h9);
        step(2);
        rd_chk("os_count_e2", 2'd2, 32'd5);
        step(5);
        rd_chk("os_count_e7", 2'd2, 32'd0);
        chk("os_irq_e7", bus.irq, 1'b0);
        step(1);
        chk("os_irq_e8", bus.irq, 1'b1);
        step(1);
        rd_chk("os_ctrl_after", 2'd0, 32'h8);
        chk("os_irq_held", bus.irq, 1'b1);
        wr(2'd0, 32'h8);
        chk("os_ack", bus.irq, 1'b0);

        wr(2'd1, 32'd2);
        wr(2'd0, 32'h1);
        step(6);
        chk("mask_irq", bus.irq, 1'b0);
        rd_chk("mask_ctrl", 2'd0, 32'h0);
        wr(2'd0, 32'h8);
        chk("mask_unmask", bus.irq, 1'b1);
        wr(2'd0, 32'h8);
        chk("mask_ack", bus.irq, 1'b0);

        wr(2'd1, 32'd10);
        wr(2'd0, 32'h9);
        step(3);
        wr(2'd0, 32'h8);
        step(3);
        rd_chk("dis_freeze", 2'd2, 32'd7);
        chk("dis_irq", bus.irq, 1'b0);
        wr(2'd0, 32'h9);
        step(2);
        rd_chk("dis_reload", 2'd2, 32'd10);
        wr(2'd0, 32'h0);

        wr(2'd1, 32'd0);
        wr(2'd0, 32'h9);
        step(2);
        chk("p0_irq_e2", bus.irq, 1'b0);
        step(1);
        chk("p0_irq_e3", bus.irq, 1'b1);
        wr(2'd0, 32'h8);
        wr(2'd2, 32'h55);
        rd_chk("count_ro", 2'd2, 32'd0);

        wr(2'd1, 32'd3);
        wr(2'd0, 32'hB);
        rd_chk("ar_ctrl", 2'd0, AUTO ? 32'hB : 32'h9);
        step(5);
        chk("ar_irq_e5", bus.irq, 1'b0);
        step(1);
        chk("ar_irq_e6", bus.irq, 1'b1);
        step(1);
        chk("ar_irq_e7", bus.irq, AUTO ? 1'b0 : 1'b1);
        step(3);
        chk("ar_irq_e10", bus.irq, AUTO ? 1'b0 : 1'b1);
        step(1);
        chk("ar_irq_e11", bus.irq, 1'b1);

        reset = 1'b1;
        step(1);
        reset = 1'b0;
        wr(2'd1, 32'd20);
        wr(2'd0, 32'h9);
        step(3);
        reset = 1'b1;
        step(1);
        reset = 1'b0;
        rd_chk("rst_mid_count", 2'd2, 32'd0);
        chk("rst_mid_irq", bus.irq, 1'b0);

        for (int i = 0; i < 4000; i++) begin
            logic [31:0] d;
            @(posedge clk); #1;
            reset = ($urandom % 300) == 0;
            bus.addr = 2'($urandom);
            bus.we = ($urandom % 5) == 0;
            d = $urandom;
            if (bus.addr == 2'd1 && ($urandom % 8) != 0)
                d = $urandom_range(0, 12);
            if (bus.addr == 2'd0)
                d[0] = ($urandom % 4) != 0;
            bus.din = d;
        end
        @(posedge clk); #1;
        bus.we = 1'b0;
        reset = 1'b0;
        step(2);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
